display_scan: RTL and testbench
===============================

# display_scan

Sequential digit scanner for the 4-digit 7-segment display. It drives the `displayMux` digit select, samples the returned nibble and decimal-point flag, and encodes them to segments. It strobes one digit enable at a time with a dark interval between digits to prevent ghosting, and optionally blanks leading zeros. It sits between `displayMux` and the board display pins.

## Interface
Parameters:
- `SCAN_DIV`, 50_000: clock cycles per digit slot (1 kHz/digit at 50 MHz). Legal range is at least 2.
- `BLANK_CYCLES`, 500: dark cycles at the start of each slot. Legal range is 1 ≤ `BLANK_CYCLES` < `SCAN_DIV`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  scanning enable. When 0, the display is dark.
- `lz_en`  in  1  leading-zero blanking enable
- `digit`  out  2  digit select to `displayMux` (3 = leftmost)
- `num`  in  4  nibble from `displayMux`. Codes: 0–9 are numerals, 4'hA is minus, 4'hF is blank, and 4'hB–4'hE are blank.
- `decimal`  in  1  decimal point for the selected digit, from `displayMux`
- `seg`  out  8  segments, active-low. Bit 7 = dp, bits 6:0 = g..a.
- `ct`  out  4  digit enables, one-hot, active-high. `ct[i]` lights digit i.
- `frame`  out  1  one-cycle pulse at the end of each full 4-digit scan

## Operation
- The FSM has three states: IDLE, BLANK and SHOW.
  - **IDLE:** `ct`=0, `seg`=8'hFF, `digit`=3.
    - When `en`=1, go to BLANK and load the slot counter with 0.
  - **BLANK:** `ct`=0 and `digit` holds the current digit. The counter increments each cycle.
    - On the cycle with counter = `BLANK_CYCLES`-1, sample `num`/`decimal`, register the encoded `seg`, and go to SHOW.
  - **SHOW:** `ct` is one-hot for `digit`, and `seg` holds the sampled value.
    - On counter = `SCAN_DIV`-1, go to BLANK and clear the counter.
    - On the same edge, `digit` steps 3→2→1→0→3 (wrap from 0 back to 3).
- **`frame`:** asserted for exactly one cycle on the edge that leaves SHOW of digit 0.
- **Sampling:** `num` is sampled only on the last BLANK cycle. Changes to `num` during SHOW do not affect `seg` until the next slot.
- **Leading-zero blanking:** a register `nz` is cleared on entry to BLANK for digit 3 and set by any sampled numeral 1–9.
  - For digits 3..1, if `lz_en`=1, `nz`=0 and the sampled `num`=0, the digit encodes as blank.
  - Digit 0 is never zero-blanked.
  - Minus (4'hA) does not set `nz`.
  - `decimal` is always honoured, including on a zero-blanked digit, where only the dp lights.
- **Encoding:** standard 7-segment patterns for 0–9. Minus lights segment g only. Blank codes give 7'h7F (all segments off).
- **`en` deasserted:** in any state, on the next edge go to IDLE. Apply the IDLE outputs, reset `digit` to 3 and clear the counter. No `frame` pulse.
- **`en`=1 while in IDLE:** a fresh scan starts from digit 3.
- **`lz_en` change mid-frame:** takes effect at the next sample. No glitch within a slot.

## Timing
- **Reset values:** state IDLE, `ct`=4'b0000, `seg`=8'hFF, `digit`=2'd3, `frame`=0, counter=0, `nz`=0.
- **Reset mid-scan:** reset overrides `en`. All outputs take their reset values on the same edge.
- **All outputs are registered.** There is no combinational path from `num`/`decimal` to `seg`.
- **Slot length:** exactly `SCAN_DIV` cycles, of which `BLANK_CYCLES` are dark. A frame is 4×`SCAN_DIV` cycles.
- **Startup:** from `en` rising (sampled high in IDLE), the first BLANK cycle follows one edge later. `ct` is first nonzero `BLANK_CYCLES`+1 cycles after `en` is sampled.
- **`digit` stability:** `digit` changes only on SHOW→BLANK edges. It is stable for the entire slot, so `displayMux` output is settled for `BLANK_CYCLES` cycles before sampling.
- **`ct` and `digit` never disagree.** `ct` is always 0 on any cycle where `digit` has just changed.

## Structure
- **Package `display_pkg`:**
  - state enum `scan_state_t` (IDLE, BLANK, SHOW)
  - nibble constants `NUM_MINUS`=4'hA and `NUM_BLANK`=4'hF
  - segment pattern constants: `SEG_BLANK`=7'h7F, `SEG_MINUS`, and a 10-entry numeral array
- **Sub-module `seg7_encode`:** combinational (`num`, `dp`, `blank`) → `seg[7:0]`. It is instantiated once, and its output is registered in `display_scan`.
- **Counter width:** `$clog2(SCAN_DIV)`.

## Test plan
Use `SCAN_DIV`=20 and `BLANK_CYCLES`=4 for all scenarios. The bench contains a behavioural `displayMux` model driven from `digit`.

- **Reset mid-SHOW:** hold `reset` for 1 cycle during SHOW of digit 2 → same edge gives `ct`=0, `seg`=8'hFF, `digit`=3, `frame`=0. The scan restarts at digit 3 if `en`=1.
- **Basic scan:** `en`=1, `lz_en`=0, digits 3..0 = 1,2,3,4 → `ct` cycles 1000, 0100, 0010, 0001. Each is lit 16 cycles after 4 dark cycles, and `seg` matches the patterns for 1, 2, 3, 4. `frame` pulses once every 80 cycles.
- **Leading zeros:** `lz_en`=1, digits 0,0,7,0 → digits 3 and 2 have segments off with `ct` still strobing. Digit 1 shows 7 and digit 0 shows 0. With all digits 0, only digit 0 shows 0.
- **Minus and dp:** digits A,0,5,0, `lz_en`=1, `decimal` set on digit 1 → digit 3 shows g only, digit 2 is blank, digit 1 shows "5." with `seg[7]`=0, and digit 0 shows 0.
- **Sampling point:** change `num` for digit 1 from 3 to 8 in the middle of its SHOW → `seg` keeps 3 for that slot. 8 appears in the next frame's digit-1 slot.
- **Enable drop:** deassert `en` during BLANK of digit 1 → next edge gives IDLE, `ct`=0, `seg`=8'hFF, `digit`=3, and no `frame` pulse. On re-assert, `ct`=1000 appears 5 cycles later.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: scan FSM state enum, special nibble codes, active-low
// segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [3:0] NUM_MINUS = 4'hA;
    localparam logic [3:0] NUM_BLANK = 4'hF;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Index n holds the pattern for numeral n (element 0 is the rightmost).
    localparam logic [9:0][6:0] SEG_NUMERAL = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // True for numerals that end a run of leading zeros.
    function automatic logic is_nonzero_numeral(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'd9);
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Nibble + decimal point to active-low 7-segment pattern.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
//
// Ports: num   - nibble code (0-9 numeral, A minus, B-F blank)
//        dp    - decimal point request, honoured even when blanked
//        blank - force the digit segments off (leading-zero blanking)
//        seg   - {dp, g..a}, active-low
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] num,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = {~dp, SEG_BLANK};
        if (!blank) begin
            if (num <= 4'd9) begin
                seg[6:0] = SEG_NUMERAL[num];
            end else if (num == NUM_MINUS) begin
                seg[6:0] = SEG_MINUS;
            end else if (num == NUM_BLANK) begin
                seg[6:0] = SEG_BLANK;
            end
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for a 4-digit 7-segment display with anti-ghost dark gap.
// Latency: ct lights BLANK_CYCLES+1 cycles after en is sampled; all outputs registered.
// Backpressure: none; free-running while en is high, dark and parked on digit 3 otherwise.
//
// Ports: clk, reset (sync, active-high), en (scan enable), lz_en (leading-zero blanking),
//        digit (select to the display mux, 3 = leftmost), num/decimal (mux return),
//        seg (active-low {dp,g..a}), ct (one-hot digit enable), frame (end-of-scan pulse).
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50_000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       lz_en,
    output logic [1:0] digit,
    input  logic [3:0] num,
    input  logic       decimal,
    output logic [7:0] seg,
    output logic [3:0] ct,
    output logic       frame
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0]       ct_q,    ct_d;
    logic [7:0]       seg_q,   seg_d;
    logic             frame_q, frame_d;
    logic             nz_q,    nz_d;

    logic             zero_blank;
    logic [7:0]       enc_seg;

    // Digit 0 always shows, so a value of plain zero is never fully dark.
    assign zero_blank = lz_en && !nz_q && (num == 4'd0) && (digit_q != 2'd0);

    seg7_encode u_enc (
        .num   (num),
        .dp    (decimal),
        .blank (zero_blank),
        .seg   (enc_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        ct_d    = ct_q;
        seg_d   = seg_q;
        frame_d = 1'b0;
        nz_d    = nz_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = 2'd3;
            ct_d    = 4'b0000;
            seg_d   = 8'hFF;
            nz_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = 2'd3;
                    ct_d    = 4'b0000;
                    seg_d   = 8'hFF;
                    nz_d    = 1'b0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        // Mux output has been settled for the whole dark gap.
                        state_d = SHOW;
                        seg_d   = enc_seg;
                        ct_d    = 4'b0001 << digit_q;
                        if (is_nonzero_numeral(num)) begin
                            nz_d = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        // 0 - 1 wraps to 3, giving the 3,2,1,0 order for free.
                        digit_d = digit_q - 2'd1;
                        ct_d    = 4'b0000;
                        seg_d   = 8'hFF;
                        if (digit_q == 2'd0) begin
                            frame_d = 1'b1;
                            nz_d    = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = 2'd3;
                    ct_d    = 4'b0000;
                    seg_d   = 8'hFF;
                    nz_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            digit_q <= 2'd3;
            ct_q    <= 4'b0000;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            ct_q    <= ct_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            nz_q    <= nz_d;
        end
    end

    assign digit = digit_q;
    assign ct    = ct_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a behavioural display mux.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scan;

    logic       clk;
    logic       reset;
    logic       en;
    logic       lz_en;
    logic [1:0] digit;
    logic [3:0] num;
    logic       decimal;
    logic [7:0] seg;
    logic [3:0] ct;
    logic       frame;

    logic [3:0] nums [4];
    logic       dps  [4];

    int checks = 0;
    int errors = 0;

    display_scan #(
        .SCAN_DIV     (20),
        .BLANK_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .lz_en   (lz_en),
        .digit   (digit),
        .num     (num),
        .decimal (decimal),
        .seg     (seg),
        .ct      (ct),
        .frame   (frame)
    );

    // Behavioural display mux: returns the nibble/dp for the selected digit.
    assign num     = nums[digit];
    assign decimal = dps[digit];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Entered on the first dark cycle of digit d's slot; leaves on the first
    // dark cycle of the following slot.
    task automatic check_slot(input logic [1:0] d, input logic [7:0] exp_seg);
        string t;
        t = $sformatf("slot%0d", d);
        check({t, "_dark_ct"},     8'(ct),    8'h00);
        check({t, "_digit"},       8'(digit), 8'(d));
        step_n(3);
        check({t, "_dark_end_ct"}, 8'(ct),    8'h00);
        step();
        check({t, "_lit_ct"},      8'(ct),    8'(4'b0001 << d));
        check({t, "_lit_seg"},     seg,       exp_seg);
        step_n(15);
        check({t, "_lit_end_ct"},  8'(ct),    8'(4'b0001 << d));
        check({t, "_lit_end_seg"}, seg,       exp_seg);
        check({t, "_digit_hold"},  8'(digit), 8'(d));
        step();
        check({t, "_frame"},       8'(frame), 8'(d == 2'd0));
    endtask

    task automatic restart();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic set_nums(input logic [3:0] n3, input logic [3:0] n2,
                            input logic [3:0] n1, input logic [3:0] n0);
        nums[3] = n3;
        nums[2] = n2;
        nums[1] = n1;
        nums[0] = n0;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        lz_en = 1'b0;
        set_nums(4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) dps[i] = 1'b0;

        // Reset state
        step_n(2);
        check("rst_ct",    8'(ct),    8'h00);
        check("rst_seg",   seg,       8'hFF);
        check("rst_digit", 8'(digit), 8'd3);
        check("rst_frame", 8'(frame), 8'h00);
        reset = 1'b0;
        step_n(2);
        check("idle_ct",    8'(ct),    8'h00);
        check("idle_digit", 8'(digit), 8'd3);

        // Basic scan 1,2,3,4 plus the first slot of the next frame
        set_nums(4'd1, 4'd2, 4'd3, 4'd4);
        en = 1'b1;
        step();
        check_slot(2'd3, 8'hF9);
        check_slot(2'd2, 8'hA4);
        check_slot(2'd1, 8'hB0);
        check_slot(2'd0, 8'h99);
        check_slot(2'd3, 8'hF9);

        // Leading zeros: 0,0,7,0
        lz_en = 1'b1;
        set_nums(4'd0, 4'd0, 4'd7, 4'd0);
        restart();
        check_slot(2'd3, 8'hFF);
        check_slot(2'd2, 8'hFF);
        check_slot(2'd1, 8'hF8);
        check_slot(2'd0, 8'hC0);

        // All zeros: only digit 0 shows
        set_nums(4'd0, 4'd0, 4'd0, 4'd0);
        restart();
        check_slot(2'd3, 8'hFF);
        check_slot(2'd2, 8'hFF);
        check_slot(2'd1, 8'hFF);
        check_slot(2'd0, 8'hC0);

        // Minus and decimal point: A,0,5.,0
        set_nums(4'hA, 4'd0, 4'd5, 4'd0);
        dps[1] = 1'b1;
        restart();
        check_slot(2'd3, 8'hBF);
        check_slot(2'd2, 8'hFF);
        check_slot(2'd1, 8'h12);
        check_slot(2'd0, 8'hC0);
        dps[1] = 1'b0;

        // Zero-blanked digit still shows its decimal point
        set_nums(4'd0, 4'd0, 4'd0, 4'd0);
        dps[3] = 1'b1;
        restart();
        check_slot(2'd3, 8'h7F);
        dps[3] = 1'b0;

        // Sampling point: digit 1 changes 3 -> 8 mid-SHOW
        lz_en = 1'b0;
        set_nums(4'd1, 4'd2, 4'd3, 4'd4);
        restart();
        check_slot(2'd3, 8'hF9);
        check_slot(2'd2, 8'hA4);
        step_n(4);
        check("samp_lit_ct",  8'(ct), 8'h02);
        check("samp_lit_seg", seg,    8'hB0);
        step_n(8);
        nums[1] = 4'd8;
        step_n(7);
        check("samp_hold_seg", seg,    8'hB0);
        check("samp_hold_ct",  8'(ct), 8'h02);
        step();
        check_slot(2'd0, 8'h99);
        check_slot(2'd3, 8'hF9);
        check_slot(2'd2, 8'hA4);
        check_slot(2'd1, 8'h80);
        check_slot(2'd0, 8'h99);
        check_slot(2'd3, 8'hF9);

        // Reset mid-SHOW of digit 2 with en held high
        step_n(4);
        check("pre_rst_ct", 8'(ct), 8'h04);
        step_n(3);
        reset = 1'b1;
        step();
        check("mid_rst_ct",    8'(ct),    8'h00);
        check("mid_rst_seg",   seg,       8'hFF);
        check("mid_rst_digit", 8'(digit), 8'd3);
        check("mid_rst_frame", 8'(frame), 8'h00);
        reset = 1'b0;
        step();
        check_slot(2'd3, 8'hF9);
        check_slot(2'd2, 8'hA4);

        // Enable drop during BLANK of digit 1
        step_n(2);
        en = 1'b0;
        step();
        check("drop_ct",    8'(ct),    8'h00);
        check("drop_seg",   seg,       8'hFF);
        check("drop_digit", 8'(digit), 8'd3);
        check("drop_frame", 8'(frame), 8'h00);
        step_n(3);
        check("off_ct",    8'(ct),    8'h00);
        check("off_frame", 8'(frame), 8'h00);
        en = 1'b1;
        step_n(4);
        check("reen_dark_ct", 8'(ct), 8'h00);
        step();
        check("reen_lit_ct",  8'(ct),    8'h08);
        check("reen_seg",     seg,       8'hF9);
        check("reen_digit",   8'(digit), 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
